// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle: IF_ID_* fields produced by decode, ID_EX_* registered copies for EX.
// IF_ID_Valid qualifies the decode slot; there is no ready. hazard_stall is the back-pressure, and while it is high decode must hold IF_ID_* stable.
interface id_ex_stage_reg_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
);
  logic               IF_ID_Valid;
  logic [XLEN-1:0]    IF_ID_Pc;
  logic [REG_AW-1:0]  IF_ID_Rs1;
  logic [REG_AW-1:0]  IF_ID_Rs2;
  logic [REG_AW-1:0]  IF_ID_Rd;
  logic [XLEN-1:0]    IF_ID_Rs1Data;
  logic [XLEN-1:0]    IF_ID_Rs2Data;
  logic [XLEN-1:0]    IF_ID_Imm;
  logic [7:0]         IF_ID_Ctrl;
  logic [ALUOP_W-1:0] IF_ID_ALUOp;

  logic               ID_EX_Valid;
  logic [XLEN-1:0]    ID_EX_Pc;
  logic [REG_AW-1:0]  ID_EX_Rs1;
  logic [REG_AW-1:0]  ID_EX_Rs2;
  logic [REG_AW-1:0]  ID_EX_Rd;
  logic [XLEN-1:0]    ID_EX_Rs1Data;
  logic [XLEN-1:0]    ID_EX_Rs2Data;
  logic [XLEN-1:0]    ID_EX_Imm;
  logic [7:0]         ID_EX_Ctrl;
  logic [ALUOP_W-1:0] ID_EX_ALUOp;

  modport master (
    output IF_ID_Valid, IF_ID_Pc, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
           IF_ID_Rs1Data, IF_ID_Rs2Data, IF_ID_Imm, IF_ID_Ctrl, IF_ID_ALUOp,
    input  ID_EX_Valid, ID_EX_Pc, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd,
           ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm, ID_EX_Ctrl, ID_EX_ALUOp
  );

  modport slave (
    input  IF_ID_Valid, IF_ID_Pc, IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd,
           IF_ID_Rs1Data, IF_ID_Rs2Data, IF_ID_Imm, IF_ID_Ctrl, IF_ID_ALUOp,
    output ID_EX_Valid, ID_EX_Pc, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd,
           ID_EX_Rs1Data, ID_EX_Rs2Data, ID_EX_Imm, ID_EX_Ctrl, ID_EX_ALUOp
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and external-stall hold.
// Optional perf counters (stall/bubble/flush) are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
`ifdef ID_EX_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ext_stall,
  id_ex_stage_reg_if.slave   bus,
  output logic               hazard_stall
`ifdef ID_EX_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] bubble_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Ctrl bit positions: {RegWrite,MemWrite,MemRead,MemToReg,ALUSrc,Branch,Jump,UsesRs2}
  localparam int C_MEMWRITE = 6;
  localparam int C_MEMREAD  = 5;
  localparam int C_USESRS2  = 0;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic [REG_AW-1:0]  ex_rd;
  logic [XLEN-1:0]    ex_rs1_data;
  logic [XLEN-1:0]    ex_rs2_data;
  logic [XLEN-1:0]    ex_imm;
  logic [7:0]         ex_ctrl;
  logic [ALUOP_W-1:0] ex_aluop;

  logic rs1_hit;
  logic rs2_hit;
  logic lu;

  assign rs1_hit = (ex_rd == bus.IF_ID_Rs1);
  // A store whose data operand is the only match gets the load value via store-data forwarding.
  assign rs2_hit = bus.IF_ID_Ctrl[C_USESRS2] & (ex_rd == bus.IF_ID_Rs2) &
                   ~bus.IF_ID_Ctrl[C_MEMWRITE];
  assign lu = ex_valid & ex_ctrl[C_MEMREAD] & bus.IF_ID_Valid &
              (ex_rd != '0) & (rs1_hit | rs2_hit);
  assign hazard_stall = lu & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      ex_aluop    <= '0;
    end else if (flush || (!ext_stall && lu)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      ex_aluop    <= '0;
    end else if (!ext_stall) begin
      ex_valid    <= bus.IF_ID_Valid;
      ex_pc       <= bus.IF_ID_Pc;
      ex_rs1      <= bus.IF_ID_Rs1;
      ex_rs2      <= bus.IF_ID_Rs2;
      ex_rd       <= bus.IF_ID_Rd;
      ex_rs1_data <= bus.IF_ID_Rs1Data;
      ex_rs2_data <= bus.IF_ID_Rs2Data;
      ex_imm      <= bus.IF_ID_Imm;
      ex_ctrl     <= bus.IF_ID_Valid ? bus.IF_ID_Ctrl : 8'h00;
      ex_aluop    <= bus.IF_ID_ALUOp;
    end
  end

  assign bus.ID_EX_Valid   = ex_valid;
  assign bus.ID_EX_Pc      = ex_pc;
  assign bus.ID_EX_Rs1     = ex_rs1;
  assign bus.ID_EX_Rs2     = ex_rs2;
  assign bus.ID_EX_Rd      = ex_rd;
  assign bus.ID_EX_Rs1Data = ex_rs1_data;
  assign bus.ID_EX_Rs2Data = ex_rs2_data;
  assign bus.ID_EX_Imm     = ex_imm;
  assign bus.ID_EX_Ctrl    = ex_ctrl;
  assign bus.ID_EX_ALUOp   = ex_aluop;

`ifdef ID_EX_PERF_CNT_EN
  // Saturating counters; each stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (ext_stall && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (lu && !flush && !ext_stall && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard scenarios plus randomized traffic against an instruction-level model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [3:0]  op;
  } instr_t;

  localparam logic [7:0] LW  = 8'b1011_1000;
  localparam logic [7:0] ADD = 8'b1000_0001;
  localparam logic [7:0] SW  = 8'b0100_1001;

  logic clk;
  logic rst_n;
  logic flush;
  logic ext_stall;
  logic hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0] m_stall, m_bubble, m_flush;
`endif

  id_ex_stage_reg_if bus ();

  id_ex_stage_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .ext_stall    (ext_stall),
    .bus          (bus.slave),
    .hazard_stall (hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt  (stall_cnt)
    , .bubble_cnt (bubble_cnt)
    , .flush_cnt  (flush_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     vec_cnt = 0;
  int     err_cnt = 0;
  instr_t cur;     // instruction presented in decode
  instr_t m;       // instruction the model says sits in EX
  logic   last_hz;
  logic [31:0] saved_pc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a load in EX blocks any consumer reading its destination, except a store's data operand.
  function automatic logic model_lu(input instr_t ex, input instr_t id);
    logic rs1_dep, rs2_dep;
    if (!(ex.v && ex.ctrl == LW || ex.v && ex.ctrl[5])) return 1'b0;
    if (!id.v || ex.rd == 5'd0) return 1'b0;
    rs1_dep = (id.rs1 == ex.rd);
    rs2_dep = id.ctrl[0] && (id.rs2 == ex.rd);
    if (id.ctrl[6]) return rs1_dep;
    return rs1_dep || rs2_dep;
  endfunction

  task automatic drive(input instr_t s);
    cur = s;
    bus.IF_ID_Valid   = s.v;
    bus.IF_ID_Pc      = s.pc;
    bus.IF_ID_Rs1     = s.rs1;
    bus.IF_ID_Rs2     = s.rs2;
    bus.IF_ID_Rd      = s.rd;
    bus.IF_ID_Rs1Data = s.d1;
    bus.IF_ID_Rs2Data = s.d2;
    bus.IF_ID_Imm     = s.imm;
    bus.IF_ID_Ctrl    = s.ctrl;
    bus.IF_ID_ALUOp   = s.op;
  endtask

  function automatic instr_t mk(input logic [7:0] ctrl, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] pc);
    instr_t s;
    s.v = 1'b1; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
    s.ctrl = ctrl; s.op = 4'($urandom_range(0, 15));
    return s;
  endfunction

  function automatic instr_t rand_instr();
    instr_t s;
    int k;
    k = $urandom_range(0, 3);
    s = mk(k == 0 ? LW : k == 1 ? ADD : k == 2 ? SW : 8'($urandom_range(0, 255)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom);
    s.v = ($urandom_range(0, 7) != 0);
    return s;
  endfunction

  task automatic check_outputs();
    check_eq("valid", 64'(bus.ID_EX_Valid),   64'(m.v));
    check_eq("pc",    64'(bus.ID_EX_Pc),      64'(m.pc));
    check_eq("rs1",   64'(bus.ID_EX_Rs1),     64'(m.rs1));
    check_eq("rs2",   64'(bus.ID_EX_Rs2),     64'(m.rs2));
    check_eq("rd",    64'(bus.ID_EX_Rd),      64'(m.rd));
    check_eq("d1",    64'(bus.ID_EX_Rs1Data), 64'(m.d1));
    check_eq("d2",    64'(bus.ID_EX_Rs2Data), 64'(m.d2));
    check_eq("imm",   64'(bus.ID_EX_Imm),     64'(m.imm));
    check_eq("ctrl",  64'(bus.ID_EX_Ctrl),    64'(m.ctrl));
    check_eq("aluop", 64'(bus.ID_EX_ALUOp),   64'(m.op));
`ifdef ID_EX_PERF_CNT_EN
    check_eq("stall_cnt",  64'(stall_cnt),  64'(m_stall));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    check_eq("flush_cnt",  64'(flush_cnt),  64'(m_flush));
`endif
  endtask

  task automatic model_reset();
    m = '0;
`ifdef ID_EX_PERF_CNT_EN
    m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
  endtask

  // One clock: check comb hazard on current inputs, clock, advance model, check registers.
  task automatic step(input logic f, input logic s);
    logic hz;
    flush = f;
    ext_stall = s;
    #1;
    hz = model_lu(m, cur);
    last_hz = hazard_stall;
    check_eq("hazard_stall", 64'(hazard_stall), 64'(hz && !f));
    @(posedge clk);
`ifdef ID_EX_PERF_CNT_EN
    if (s && !f && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (hz && !f && !s && m_bubble != 32'hFFFF_FFFF) m_bubble++;
    if (f && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
    if (f) m = '0;
    else if (s) m = m;
    else if (hz) m = '0;
    else begin
      m = cur;
      if (!cur.v) m.ctrl = 8'h00;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    last_hz = 1'b0;
    drive(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h40));
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset mid-capture clears outputs without an edge
    step(1'b0, 1'b0);
    drive(mk(ADD, 5'd4, 5'd5, 5'd6, 32'h44));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst_n = 1'b1;
    drive(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h100));
    step(1'b0, 1'b0);
    check_eq("pc_after_reset", 64'(bus.ID_EX_Pc), 64'h100);

    // external stall holds for 3 cycles while decode changes
    saved_pc = bus.ID_EX_Pc;
    for (int i = 0; i < 3; i++) begin
      drive(mk(ADD, 5'd7, 5'd8, 5'd9, 32'h200 + 32'(i)));
      step(1'b0, 1'b1);
      check_eq("hold_pc", 64'(bus.ID_EX_Pc), 64'(saved_pc));
    end
`ifdef ID_EX_PERF_CNT_EN
    check_eq("hold_stall_cnt",  64'(stall_cnt),  64'd3);
    check_eq("hold_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif

    // load-use: lw x5 then add x6,x5,x1
    drive(mk(LW, 5'd2, 5'd0, 5'd5, 32'h300));
    step(1'b0, 1'b0);
    drive(mk(ADD, 5'd5, 5'd1, 5'd6, 32'h304));
    step(1'b0, 1'b0);
    check_eq("lu_hazard", 64'(last_hz), 64'd1);
    check_eq("lu_bubble_valid", 64'(bus.ID_EX_Valid), 64'd0);
    check_eq("lu_bubble_rd", 64'(bus.ID_EX_Rd), 64'd0);
    step(1'b0, 1'b0);
    check_eq("lu_clear", 64'(last_hz), 64'd0);
    check_eq("lu_add_rd", 64'(bus.ID_EX_Rd), 64'd6);

    // store exemption: sw x5,0(x2) after lw x5
    drive(mk(LW, 5'd2, 5'd0, 5'd5, 32'h400));
    step(1'b0, 1'b0);
    drive(mk(SW, 5'd2, 5'd5, 5'd0, 32'h404));
    step(1'b0, 1'b0);
    check_eq("sw_data_hazard", 64'(last_hz), 64'd0);
    check_eq("sw_captured", 64'(bus.ID_EX_Ctrl), 64'(SW));
    // sw x7,0(x5): base depends on the load
    drive(mk(LW, 5'd2, 5'd0, 5'd5, 32'h408));
    step(1'b0, 1'b0);
    drive(mk(SW, 5'd5, 5'd7, 5'd0, 32'h40C));
    step(1'b0, 1'b0);
    check_eq("sw_base_hazard", 64'(last_hz), 64'd1);
    step(1'b0, 1'b0);

    // x0 destination never stalls
    drive(mk(LW, 5'd2, 5'd0, 5'd0, 32'h500));
    step(1'b0, 1'b0);
    drive(mk(ADD, 5'd0, 5'd0, 5'd6, 32'h504));
    step(1'b0, 1'b0);
    check_eq("x0_hazard", 64'(last_hz), 64'd0);

    // flush beats ext_stall and load-use
    drive(mk(LW, 5'd2, 5'd0, 5'd5, 32'h600));
    step(1'b0, 1'b0);
    drive(mk(ADD, 5'd5, 5'd1, 5'd6, 32'h604));
    step(1'b1, 1'b1);
    check_eq("flush_hazard", 64'(last_hz), 64'd0);
    check_eq("flush_bubble", 64'(bus.ID_EX_Valid), 64'd0);

    // invalid slot: Ctrl forced to 0
    begin
      instr_t s;
      s = mk(LW, 5'd1, 5'd1, 5'd9, 32'h700);
      s.v = 1'b0;
      drive(s);
      step(1'b0, 1'b0);
      check_eq("invalid_ctrl", 64'(bus.ID_EX_Ctrl), 64'd0);
    end

    // randomized traffic; decode holds while hazard_stall is high
    for (int i = 0; i < 1500; i++) begin
      if (!last_hz) drive(rand_instr());
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
